// File: rtl/ps2_key_event_decoder.sv
// PS/2 scan-code set 2 key-event decoder: E0/F0/E1 prefix FSM, held-key bitmap, one event per sequence.
// Latency: event registered on the clock edge after the final byte's rx_valid; key_valid is a 1-clk strobe.
// Backpressure: none; accepts one byte per clock, back-to-back rx_valid supported.
// Ports: clk, rst (sync, active-high) | rx_byte[7:0], rx_valid in | key_down[127:0], last_change[8:0],
//        key_valid, key_make out.
// Optional feature macro: TYPEMATIC_FILTER_EN suppresses repeat makes of an already-held tracked key.
module ps2_key_event_decoder #(
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int TMO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_byte,
  input  logic         rx_valid,
  output logic [127:0] key_down,
  output logic [8:0]   last_change,
  output logic         key_valid,
  output logic         key_make
);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

  state_t           state, state_nxt, cur_state;
  logic [TMO_W-1:0] timer, timer_nxt;
  logic [2:0]       skip_cnt, skip_nxt;
  logic             timeout;
  logic             ev_fire, ev_ext, ev_make;
  logic             tracked, emit;

  // A stalled partial sequence is abandoned; a byte arriving on that same
  // cycle is decoded as though the FSM were already back in IDLE.
  always_comb begin
    timeout   = (state != IDLE) && (timer == TMO_W'(TIMEOUT_CYCLES));
    cur_state = timeout ? IDLE : state;
  end

  always_comb begin
    state_nxt = cur_state;
    skip_nxt  = skip_cnt;
    timer_nxt = '0;
    ev_fire   = 1'b0;
    ev_ext    = 1'b0;
    ev_make   = 1'b0;
    if (!rx_valid && (state != IDLE) && !timeout)
      timer_nxt = timer + 1'b1;
    if (rx_valid) begin
      case (cur_state)
        IDLE: begin
          case (rx_byte)
            8'hE0: state_nxt = EXT;
            8'hF0: state_nxt = BRK;
            8'hE1: begin
              state_nxt = SKIP;
              skip_nxt  = 3'd7;
            end
            // keyboard status/ack responses, never key codes
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFF: state_nxt = IDLE;
            default: begin
              ev_fire = 1'b1;
              ev_make = 1'b1;
            end
          endcase
        end
        EXT: begin
          case (rx_byte)
            8'hF0: state_nxt = EXT_BRK;
            8'hE0: state_nxt = EXT;
            8'h12, 8'h59: state_nxt = IDLE;  // fake shift emitted around extended keys
            default: begin
              ev_fire   = 1'b1;
              ev_ext    = 1'b1;
              ev_make   = 1'b1;
              state_nxt = IDLE;
            end
          endcase
        end
        BRK: begin
          case (rx_byte)
            8'hF0: state_nxt = BRK;
            8'hE0: state_nxt = EXT_BRK;
            default: begin
              ev_fire   = 1'b1;
              state_nxt = IDLE;
            end
          endcase
        end
        EXT_BRK: begin
          state_nxt = IDLE;
          if (rx_byte != 8'h12 && rx_byte != 8'h59) begin
            ev_fire = 1'b1;
            ev_ext  = 1'b1;
          end
        end
        SKIP: begin
          skip_nxt = skip_cnt - 3'd1;
          if (skip_cnt == 3'd1)
            state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Only plain (non-extended) codes below 0x80 have a bitmap slot.
  always_comb begin
    tracked = !ev_ext && !rx_byte[7];
`ifdef TYPEMATIC_FILTER_EN
    emit = ev_fire && !(ev_make && tracked && key_down[rx_byte[6:0]]);
`else
    emit = ev_fire;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      skip_cnt    <= 3'd0;
      key_down    <= '0;
      last_change <= 9'h000;
      key_valid   <= 1'b0;
      key_make    <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      skip_cnt  <= skip_nxt;
      key_valid <= emit;
      if (emit) begin
        last_change <= {ev_ext, rx_byte};
        key_make    <= ev_make;
        if (tracked)
          key_down[rx_byte[6:0]] <= ev_make;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Bench for ps2_key_event_decoder: directed vector table, timeout sequences, randomized run vs. model.
module tb_ps2_key_event_decoder;
  localparam int T = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   rx_byte = 8'h00;
  logic         rx_valid = 1'b0;
  logic [127:0] key_down;
  logic [8:0]   last_change;
  logic         key_valid;
  logic         key_make;

  int errors = 0;
  int checks = 0;

  ps2_key_event_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .key_down(key_down), .last_change(last_change), .key_valid(key_valid), .key_make(key_make)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           r;
    bit           v;
    logic [7:0]   b;
    bit           ev;
    logic [8:0]   lc;
    bit           mk;
    logic [127:0] kd;
  } vec_t;

  vec_t vt[$];

`ifdef TYPEMATIC_FILTER_EN
  localparam bit REP = 1'b0;
`else
  localparam bit REP = 1'b1;
`endif

  function automatic void add(input bit r, input bit v, input logic [7:0] b, input bit ev,
                              input logic [8:0] lc, input bit mk, input logic [127:0] kd);
    vec_t x;
    x.r = r; x.v = v; x.b = b; x.ev = ev; x.lc = lc; x.mk = mk; x.kd = kd;
    vt.push_back(x);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [7:0] b);
    rst = r; rx_valid = v; rx_byte = b;
    @(posedge clk);
    #1;
    rst = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic chk_all(input string tag, input bit ev, input logic [8:0] lc, input bit mk,
                         input logic [127:0] kd);
    chk({tag, ".key_valid"}, 128'(key_valid), 128'(ev));
    chk({tag, ".last_change"}, 128'(last_change), 128'(lc));
    chk({tag, ".key_make"}, 128'(key_make), 128'(mk));
    chk({tag, ".key_down"}, key_down, kd);
  endtask

  // ---------------- reference model: prefix flags + absolute edge timestamps ----------------
  bit           m_ext, m_brk;
  int           m_skip;
  int           m_edge, m_last_rx;
  bit           m_valid, m_make;
  logic [8:0]   m_lc;
  logic [127:0] m_kd;

  function automatic void m_emit(input bit ext, input bit make, input logic [7:0] b);
    bit trk;
    trk = !ext && (b < 8'h80);
`ifdef TYPEMATIC_FILTER_EN
    if (make && trk && m_kd[b]) return;
`endif
    m_valid = 1'b1;
    m_lc    = {ext, b};
    m_make  = make;
    if (trk) m_kd[b] = make;
  endfunction

  function automatic void model(input bit r, input bit v, input logic [7:0] b);
    m_valid = 1'b0;
    m_edge++;
    if (r) begin
      m_ext = 0; m_brk = 0; m_skip = 0; m_lc = '0; m_make = 0; m_kd = '0;
      return;
    end
    // A pending sequence dies on the (T+1)-th edge after its last byte.
    if ((m_ext || m_brk || m_skip > 0) && (m_edge - m_last_rx == T + 1)) begin
      m_ext = 0; m_brk = 0; m_skip = 0;
    end
    if (!v) return;
    m_last_rx = m_edge;
    if (m_skip > 0) begin
      m_skip--;
    end else if (!m_ext && !m_brk) begin
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE1) m_skip = 7;
      else if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFF})) m_emit(1'b0, 1'b1, b);
    end else if (!(m_ext && m_brk) && b == 8'hE0) begin
      m_ext = 1;
    end else if (!(m_ext && m_brk) && b == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (!(m_ext && (b == 8'h12 || b == 8'h59))) m_emit(m_ext, !m_brk, b);
      m_ext = 0; m_brk = 0;
    end
  endfunction

  function automatic logic [7:0] pick_byte();
    logic [7:0] ign [6];
    logic [7:0] hot [4];
    ign = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFF};
    hot = '{8'h1C, 8'h2B, 8'h33, 8'h7F};
    case ($urandom_range(0, 11))
      0, 1: return 8'hE0;
      2, 3: return 8'hF0;
      4:    return ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h1C;
      5:    return ign[$urandom_range(0, 5)];
      6:    return ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
      7, 8, 9: return hot[$urandom_range(0, 3)];
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  localparam logic [127:0] K28  = 128'h1 << 28;
  localparam logic [127:0] K43  = 128'h1 << 43;
  localparam logic [127:0] K117 = 128'h1 << 117;

  initial begin
    // ---------------- directed vector table ----------------
    add(1, 0, 8'h00, 0, 9'h000, 0, '0);          // reset state
    add(0, 1, 8'h1C, 1, 9'h01C, 1, K28);         // make 1C
    add(0, 0, 8'h00, 0, 9'h01C, 1, K28);         // pulse lasts one clock
    add(0, 1, 8'hF0, 0, 9'h01C, 1, K28);
    add(0, 1, 8'h1C, 1, 9'h01C, 0, '0);          // break 1C
    add(0, 1, 8'hE0, 0, 9'h01C, 0, '0);
    add(0, 1, 8'h75, 1, 9'h175, 1, '0);          // extended make
    add(0, 1, 8'hE0, 0, 9'h175, 1, '0);
    add(0, 1, 8'hF0, 0, 9'h175, 1, '0);
    add(0, 1, 8'h75, 1, 9'h175, 0, '0);          // extended break
    add(0, 1, 8'hAA, 0, 9'h175, 0, '0);          // ignored in IDLE
    add(0, 1, 8'hE0, 0, 9'h175, 0, '0);
    add(0, 1, 8'h12, 0, 9'h175, 0, '0);          // fake shift make
    add(0, 1, 8'hE0, 0, 9'h175, 0, '0);
    add(0, 1, 8'hF0, 0, 9'h175, 0, '0);
    add(0, 1, 8'h59, 0, 9'h175, 0, '0);          // fake shift break
    add(0, 1, 8'h83, 1, 9'h083, 1, '0);          // untracked code
    add(0, 1, 8'hF0, 0, 9'h083, 1, '0);
    add(0, 1, 8'h83, 1, 9'h083, 0, '0);
    add(0, 1, 8'h1C, 1, 9'h01C, 1, K28);
    add(0, 1, 8'h1C, REP, 9'h01C, 1, K28);       // auto-repeat
    add(0, 1, 8'h1C, REP, 9'h01C, 1, K28);
    add(0, 1, 8'hE1, 0, 9'h01C, 1, K28);         // pause sequence: 7 bytes swallowed
    add(0, 1, 8'h14, 0, 9'h01C, 1, K28);
    add(0, 1, 8'h77, 0, 9'h01C, 1, K28);
    add(0, 1, 8'hE1, 0, 9'h01C, 1, K28);
    add(0, 1, 8'hF0, 0, 9'h01C, 1, K28);
    add(0, 1, 8'h14, 0, 9'h01C, 1, K28);
    add(0, 1, 8'hF0, 0, 9'h01C, 1, K28);
    add(0, 1, 8'h77, 0, 9'h01C, 1, K28);
    add(0, 1, 8'h2B, 1, 9'h02B, 1, K28 | K43);
    add(0, 1, 8'hF0, 0, 9'h02B, 1, K28 | K43);
    add(1, 1, 8'h1C, 0, 9'h000, 0, '0);          // reset wins over rx_valid, prefix lost
    add(0, 1, 8'h1C, 1, 9'h01C, 1, K28);

    @(posedge clk); #1;
    foreach (vt[i]) begin
      step(vt[i].r, vt[i].v, vt[i].b);
      chk_all($sformatf("vec%0d", i), vt[i].ev, vt[i].lc, vt[i].mk, vt[i].kd);
    end

    // ---------------- timeout corners ----------------
    // one cycle before the deadline the prefix still applies
    step(0, 1, 8'hE0);
    for (int i = 0; i < T - 1; i++) begin
      step(0, 0, 8'h00);
      chk("tmoA.quiet", 128'(key_valid), 128'(0));
    end
    step(0, 1, 8'h75);
    chk_all("tmoA", 1, 9'h175, 1, K28);
    // byte on the timeout cycle is decoded from IDLE
    step(0, 1, 8'hE0);
    for (int i = 0; i < T; i++) step(0, 0, 8'h00);
    step(0, 1, 8'h75);
    chk_all("tmoB", 1, 9'h075, 1, K28 | K117);
    // release 1C, then dangling E0 followed by long silence
    step(0, 1, 8'hF0);
    step(0, 1, 8'h1C);
    chk_all("tmoC.brk", 1, 9'h01C, 0, K117);
    step(0, 1, 8'hE0);
    for (int i = 0; i < T + 1; i++) begin
      step(0, 0, 8'h00);
      chk("tmoC.quiet", 128'(key_valid), 128'(0));
    end
    step(0, 1, 8'h1C);
    chk_all("tmoC", 1, 9'h01C, 1, K28 | K117);

    // ---------------- randomized run against the model ----------------
    m_edge = 0; m_last_rx = 0;
    model(1'b1, 1'b0, 8'h00);
    step(1, 0, 8'h00);
    begin
      int gap = 0;
      for (int c = 0; c < 4000; c++) begin
        bit r, v;
        logic [7:0] b;
        r = ($urandom_range(0, 299) == 0);
        b = pick_byte();
        if (gap > 0) begin
          v = 1'b0;
          gap--;
        end else begin
          v = ($urandom_range(0, 9) < 6);
          if ($urandom_range(0, 39) == 0) gap = $urandom_range(T - 1, T + 2);
        end
        model(r, v, b);
        step(r, v, b);
        chk_all("rnd", m_valid, m_lc, m_make, m_kd);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
